// File: rtl/ep_cpl_pkg.sv
// Shared types for the completion scheduler: header layout and FSM state encoding.
package ep_cpl_pkg;

  localparam int unsigned CPL_HDR_W = 63;

  typedef struct packed {
    logic        with_data;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
  } cpl_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } sched_state_e;

endpackage

// File: rtl/ep_cpl_slot.sv
// One-deep completion header holding slot with capture, clear and overflow detect.
module ep_cpl_slot
  import ep_cpl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap_i,
  input  logic [CPL_HDR_W-1:0] hdr_i,
  input  logic                 clr_i,
  output logic                 valid_o,
  output logic [CPL_HDR_W-1:0] hdr_o,
  output logic                 ovf_o
);

  // A capture on the retiring edge reloads the slot instead of overflowing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      hdr_o   <= '0;
    end else if (cap_i && (!valid_o || clr_i)) begin
      valid_o <= 1'b1;
      hdr_o   <= hdr_i;
    end else if (clr_i) begin
      valid_o <= 1'b0;
    end
  end

  assign ovf_o = cap_i & valid_o & ~clr_i;

endmodule

// File: rtl/ep_cpl_scheduler.sv
// Round-robin arbiter sharing the TX completion engine between two requesters,
// with a watchdog that retires a completion whose done pulse never arrives.
module ep_cpl_scheduler
  import ep_cpl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 src0_req_i,
  input  logic [CPL_HDR_W-1:0] src0_hdr_i,
  output logic                 src0_done_o,
  input  logic                 src1_req_i,
  input  logic [CPL_HDR_W-1:0] src1_hdr_i,
  output logic                 src1_done_o,
  output logic                 txe_req_o,
  output logic [CPL_HDR_W-1:0] txe_hdr_o,
  input  logic                 txe_compl_done_i,
  output logic                 rx_np_ok_o,
  output logic                 ovf_err_o,
  output logic                 timeout_err_o
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TMR_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  sched_state_e         state;
  logic                 grant;
  logic                 rr_last;
  logic [TIMER_W-1:0]   timer;

  logic                 v0, v1, ovf0, ovf1;
  logic [CPL_HDR_W-1:0] h0, h1;
  logic                 retire, pick;

  assign retire = (state == ST_WAIT_DONE) && (txe_compl_done_i || (timer == TMR_MAX));
  assign pick   = (v0 && v1) ? ~rr_last : v1;

  ep_cpl_slot u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap_i   (src0_req_i),
    .hdr_i   (src0_hdr_i),
    .clr_i   (retire & ~grant),
    .valid_o (v0),
    .hdr_o   (h0),
    .ovf_o   (ovf0)
  );

  ep_cpl_slot u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap_i   (src1_req_i),
    .hdr_i   (src1_hdr_i),
    .clr_i   (retire & grant),
    .valid_o (v1),
    .hdr_o   (h1),
    .ovf_o   (ovf1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant         <= 1'b0;
      rr_last       <= 1'b1;
      timer         <= '0;
      txe_req_o     <= 1'b0;
      txe_hdr_o     <= '0;
      src0_done_o   <= 1'b0;
      src1_done_o   <= 1'b0;
      ovf_err_o     <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      txe_req_o   <= 1'b0;
      src0_done_o <= 1'b0;
      src1_done_o <= 1'b0;
      if (ovf0 || ovf1) ovf_err_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (v0 || v1) begin
            grant     <= pick;
            txe_hdr_o <= pick ? h1 : h0;
            txe_req_o <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (retire) begin
            src0_done_o <= ~grant;
            src1_done_o <= grant;
            rr_last     <= grant;
            state       <= ST_IDLE;
            if (!txe_compl_done_i) timeout_err_o <= 1'b1;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_np_ok_o = ~v0;

endmodule
